dec_ssm_bit_window: RTL
=======================

# dec_ssm_bit_window

Per-substream bit-window buffer for the decoder's substream multiplexer (SSM) path. It accepts 32-bit words from the substream FIFO and keeps a 256-bit MSB-first staging buffer. It presents the next 128 unread bits as an aligned window to the MPP suffix parser, and removes however many bits the parser reports it used (qres_size) in that cycle. One instance exists per substream.

## Interface
Parameters:
- ssm_idx, 0, substream index; carried for debug/assertion messages only.
- IN_W, 32, input word width; fixed at 32, other values unsupported.
- WIN_W, 128, output window width; fixed at 128.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered bits (block/slice boundary).
- in_data  in  32  next substream word, first bit at [31].
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept a word this cycle.
- win_data  out  128  next unread bits, oldest at [127].
- win_valid  out  1  at least 128 bits buffered.
- cons_valid  in  1  consume request this cycle.
- cons_bits  in  8  bits to remove, 0..128 (driven from parser qres_size).
- fill_lvl  out  9  buffered bit count, 0..256.
- err  out  1  sticky protocol error.

## Operation
- State:
  - buf[255:0] holds valid bits left-justified; bits below the fill level are don't-care but kept at 0.
  - fill[8:0] is the buffered bit count.
- Combinational outputs:
  - win_data = buf[255:128].
  - win_valid = (fill >= 128).
  - in_ready = !rst && (fill <= 224).
  - fill_lvl = fill.
- Push: occurs when in_valid && in_ready.
- Consume is legal when cons_valid && win_valid && cons_bits <= 128.
  - Any other asserted cons_valid sets err and is ignored: no bits removed, any push that cycle still completes.
- Next-state order per cycle:
  1. Determine c = legal consume ? cons_bits : 0.
  2. Shift buf left by c, zero-filling.
  3. If pushing, place in_data at buf[255-(fill-c) -: 32].
  4. Update fill = fill - c + (push ? 32 : 0).
- Push and consume in the same cycle are fully supported. in_ready is computed from the current fill, so fill never exceeds 256.
- cons_bits = 0 with cons_valid is legal and changes nothing.
- cons_bits = 128 with fill = 128 and no push empties the buffer: fill = 0, buf = 0.
- Priority: rst > flush > push/consume.
  - flush clears buf and fill and drops any same-cycle push or consume.
  - flush leaves err unchanged.
- err clears only on rst.
- Reset values:
  - buf = 0, fill = 0, err = 0.
  - Outputs: win_data = 0, win_valid = 0, fill_lvl = 0, in_ready = 0 while rst is high and 1 on the first cycle after.
- Reset mid-operation discards all buffered bits. No partial state survives.

## Timing
- Register updates take effect on the rising edge after the request. win_data, win_valid and fill_lvl reflect a consume or push on cycle N+1.
- No combinational path from in_valid, cons_valid or cons_bits to any output. in_ready depends only on fill and rst.
- The parser may consume every cycle, provided win_valid stays high.
- Sustained throughput limit is 32 bits/cycle in. A parser consuming more per cycle drains the buffer below 128 and sees win_valid drop.
- Latency from the first word pushed into an empty buffer to win_valid = 1 is 4 accepted words; win_valid rises the cycle after the 4th is accepted.

## Structure
- Shared decoder package holds:
  - constants SSM_IN_W = 32, SSM_WIN_W = 128, SSM_BUF_W = 256;
  - width localparam for fill (9 bits).
- One sub-module, dec_ssm_win_insert: a purely combinational 256-bit left shift by c followed by a 32-bit insert at offset (fill-c).
- The top level holds registers, control and err.

## Test plan
- Fill from reset:
  - Stimulus: push 0xA5A5A5A5, 0x12345678, 0xDEADBEEF, 0x0F0F0F0F on consecutive cycles.
  - Response: win_valid first high the cycle after the 4th push; win_data = 0xA5A5A5A5_12345678_DEADBEEF_0F0F0F0F; fill_lvl = 128.
- Odd consume:
  - Stimulus: from the state above plus 0xFFFFFFFF pushed (fill 160), consume 36 with no push.
  - Response: next cycle fill_lvl = 124, win_valid = 0, win_data[127:96] = 0x2345678D.
- Simultaneous push and consume:
  - Stimulus: at fill = 200, push a word and consume 60 in the same cycle.
  - Response: fill_lvl = 172; the pushed word appears at window bit offset 140 (not in window), verified after a further consume of 64.
- Backpressure:
  - Stimulus: fill to 232 with in_valid held high.
  - Response: in_ready = 0 and no word lost; after consume 8, fill = 224 and in_ready = 1 the following cycle.
- Illegal consume:
  - Stimulus: cons_bits = 129 at fill 200; separately cons_valid with fill = 100.
  - Response: err = 1 and fill unchanged; err stays 1 through flush and clears only on rst.
- Reset/flush mid-stream:
  - Stimulus: assert flush together with push and consume at fill 180.
  - Response: next cycle fill_lvl = 0, win_data = 0.
  - Repeat with rst: in_ready = 0 during rst, 1 the cycle after release.

Source files
------------

// File: rtl/dec_ssm_bit_window_pkg.sv
// Shared constants for the SSM bit-window buffer.
package dec_ssm_bit_window_pkg;

  localparam int unsigned SSM_IN_W     = 32;
  localparam int unsigned SSM_WIN_W    = 128;
  localparam int unsigned SSM_BUF_W    = 256;
  localparam int unsigned SSM_FILL_W   = 9;
  localparam int unsigned SSM_CONS_W   = 8;
  // Highest fill level at which one more input word still fits.
  localparam int unsigned SSM_PUSH_MAX = SSM_BUF_W - SSM_IN_W;

endpackage

// File: rtl/dec_ssm_bit_window_if.sv
// Word-in / window-out handshake between substream FIFO, bit window and parser.
interface dec_ssm_bit_window_if;
  import dec_ssm_bit_window_pkg::*;

  logic [SSM_IN_W-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [SSM_WIN_W-1:0]  win_data;
  logic                  win_valid;
  logic                  cons_valid;
  logic [SSM_CONS_W-1:0] cons_bits;

  modport master (
    output in_data, in_valid, cons_valid, cons_bits,
    input  in_ready, win_data, win_valid
  );

  modport slave (
    input  in_data, in_valid, cons_valid, cons_bits,
    output in_ready, win_data, win_valid
  );

endinterface

// File: rtl/dec_ssm_win_insert.sv
// Combinational shift-out of consumed bits followed by a word insert at the new tail.
module dec_ssm_win_insert
  import dec_ssm_bit_window_pkg::*;
(
  input  logic [SSM_BUF_W-1:0]  buf_q,
  input  logic [SSM_FILL_W-1:0] fill,
  input  logic [SSM_CONS_W-1:0] shift,
  input  logic                  ins_en,
  input  logic [SSM_IN_W-1:0]   ins_data,
  output logic [SSM_BUF_W-1:0]  buf_d
);

  logic [SSM_FILL_W-1:0] pos;
  logic [SSM_BUF_W-1:0]  ins_word;

  // Left-justified shift; bits below the fill level are zero so OR-insert is safe.
  always_comb begin
    pos      = fill - SSM_FILL_W'(shift);
    ins_word = {ins_data, (SSM_BUF_W - SSM_IN_W)'(0)} >> pos;
    buf_d    = buf_q << shift;
    if (ins_en) begin
      buf_d = buf_d | ins_word;
    end
  end

endmodule

// File: rtl/dec_ssm_bit_window.sv
// Per-substream 256-bit staging buffer presenting a 128-bit aligned window to the parser.
module dec_ssm_bit_window
  import dec_ssm_bit_window_pkg::*;
#(
  parameter int unsigned ssm_idx = 0,
  parameter int unsigned IN_W    = 32,
  parameter int unsigned WIN_W   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  dec_ssm_bit_window_if.slave   bus,
  output logic [SSM_FILL_W-1:0] fill_lvl,
  output logic                  err
);

  if (IN_W != SSM_IN_W || WIN_W != SSM_WIN_W) begin : g_bad_width
    $error("dec_ssm_bit_window[%0d]: only IN_W=32 and WIN_W=128 are supported", ssm_idx);
  end

  logic [SSM_BUF_W-1:0]  buf_q, buf_d, buf_ins;
  logic [SSM_FILL_W-1:0] fill_q, fill_d;
  logic                  err_q, err_d;
  logic                  in_ready, win_valid;
  logic                  push, cons_ok, cons_bad;
  logic [SSM_CONS_W-1:0] cons_amt;

  assign win_valid    = fill_q >= SSM_FILL_W'(SSM_WIN_W);
  assign in_ready     = !rst && (fill_q <= SSM_FILL_W'(SSM_PUSH_MAX));
  assign bus.in_ready = in_ready;
  assign bus.win_valid = win_valid;
  assign bus.win_data = buf_q[SSM_BUF_W-1 -: SSM_WIN_W];
  assign fill_lvl     = fill_q;
  assign err          = err_q;

  // Classify this cycle's push and consume requests.
  always_comb begin
    push     = bus.in_valid && in_ready;
    cons_ok  = bus.cons_valid && win_valid &&
               (bus.cons_bits <= SSM_CONS_W'(SSM_WIN_W));
    cons_bad = bus.cons_valid && !cons_ok;
    cons_amt = cons_ok ? bus.cons_bits : '0;
  end

  dec_ssm_win_insert u_insert (
    .buf_q    (buf_q),
    .fill     (fill_q),
    .shift    (cons_amt),
    .ins_en   (push),
    .ins_data (bus.in_data),
    .buf_d    (buf_ins)
  );

  // Next-state: flush overrides push/consume but never touches the sticky error.
  always_comb begin
    buf_d  = buf_ins;
    fill_d = fill_q - SSM_FILL_W'(cons_amt) +
             (push ? SSM_FILL_W'(SSM_IN_W) : SSM_FILL_W'(0));
    err_d  = err_q | cons_bad;
    if (flush) begin
      buf_d  = '0;
      fill_d = '0;
      err_d  = err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      err_q  <= err_d;
    end
  end

endmodule
